// File: rtl/pulse_train_gen_pkg.sv
// Shared definitions for the pulse train generator: default field widths
// and the FSM state encoding.
package pulse_train_gen_pkg;

    localparam int unsigned WIDTH_W_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/phase_counter.sv
// Loadable, non-wrapping down-counter with a terminal-count flag.
//   clk, rst     : clock, asynchronous active-high reset
//   load         : load load_val (takes priority over dec)
//   load_val     : value to load
//   dec          : decrement by one; holds at zero
//   last_c       : combinational flag, count is at its final step (<= 1)
module phase_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last_c
);

    logic [W-1:0] count;

    // Down-count; saturates at zero instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last_c = (count <= W'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Generates a train of n_pulses pulses, each width clocks high separated by
// gap clocks low, followed by a one-cycle done strobe.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request a train (accepted only in IDLE, abort has priority)
//   abort     : terminate any train in progress
//   width     : high time per pulse in clocks (0 treated as 1)
//   gap       : low time between pulses in clocks (0 treated as 1)
//   n_pulses  : number of pulses (0 gives an immediate done)
//   pulse     : registered pulse train
//   busy      : registered, high while a train is in progress
//   done      : registered one-cycle strobe on normal completion
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int unsigned WIDTH_W = WIDTH_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH_W-1:0] width,
    input  logic [WIDTH_W-1:0] gap,
    input  logic [CNT_W-1:0]   n_pulses,
    output logic               pulse,
    output logic               busy,
    output logic               done
);

    state_t             state;
    logic [WIDTH_W-1:0] width_lat;
    logic [WIDTH_W-1:0] gap_lat;

    logic               start_ok_c;
    logic [WIDTH_W-1:0] width_eff_c;
    logic [WIDTH_W-1:0] gap_eff_c;

    logic               ph_load_c;
    logic [WIDTH_W-1:0] ph_val_c;
    logic               ph_dec_c;
    logic               ph_last_c;
    logic               pc_load_c;
    logic               pc_dec_c;
    logic               pc_last_c;

    assign start_ok_c  = (state == ST_IDLE) && start && !abort;
    assign width_eff_c = (width == '0) ? WIDTH_W'(1) : width;
    assign gap_eff_c   = (gap == '0) ? WIDTH_W'(1) : gap;

    // Counter control: load the phase timer on each phase entry, otherwise
    // tick it; the pulse counter ticks once at the end of every high phase.
    always_comb begin
        ph_load_c = 1'b0;
        ph_val_c  = width_lat;
        ph_dec_c  = 1'b0;
        pc_load_c = 1'b0;
        pc_dec_c  = 1'b0;
        if (start_ok_c) begin
            ph_load_c = 1'b1;
            ph_val_c  = width_eff_c;
            pc_load_c = 1'b1;
        end else if (!abort) begin
            case (state)
                ST_HIGH: begin
                    if (ph_last_c) begin
                        pc_dec_c = 1'b1;
                        if (!pc_last_c) begin
                            ph_load_c = 1'b1;
                            ph_val_c  = gap_lat;
                        end
                    end else begin
                        ph_dec_c = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (ph_last_c) begin
                        ph_load_c = 1'b1;
                        ph_val_c  = width_lat;
                    end else begin
                        ph_dec_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    phase_counter #(.W(WIDTH_W)) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (ph_load_c),
        .load_val (ph_val_c),
        .dec      (ph_dec_c),
        .last_c   (ph_last_c)
    );

    phase_counter #(.W(CNT_W)) u_pulse_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load_c),
        .load_val (n_pulses),
        .dec      (pc_dec_c),
        .last_c   (pc_last_c)
    );

    // Train sequencer; outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pulse     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            width_lat <= '0;
            gap_lat   <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
            pulse <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        width_lat <= width_eff_c;
                        gap_lat   <= gap_eff_c;
                        if (n_pulses == '0) begin
                            state <= ST_DONE;
                            pulse <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_HIGH;
                            pulse <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (ph_last_c) begin
                        pulse <= 1'b0;
                        if (pc_last_c) begin
                            // Last pulse: no trailing gap.
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOW;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    if (ph_last_c) begin
                        state <= ST_HIGH;
                        pulse <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    pulse <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: a per-cycle reference model builds the
// expected {pulse,busy,done} sequence of each train from its fields, pushes one
// expectation per cycle, and a monitor compares after every rising edge.
module tb_pulse_train_gen;

    localparam int unsigned WW = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] width = '0;
    logic [WW-1:0] gap = '0;
    logic [CW-1:0] n_pulses = '0;
    logic          pulse;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];   // expected outputs awaiting the monitor
    logic [2:0] plan[$];    // remaining outputs of the current train
    logic [2:0] cur = 3'b000;
    logic [2:0] mon_e;

    always #5 clk = ~clk;

    pulse_train_gen #(.WIDTH_W(WW), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .width    (width),
        .gap      (gap),
        .n_pulses (n_pulses),
        .pulse    (pulse),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: {pulse,busy,done} got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Whole-train expectation from the field values.
    function automatic void build_plan(input logic [WW-1:0] w, input logic [WW-1:0] g,
                                       input logic [CW-1:0] n);
        int hi = (w == 0) ? 1 : int'(w);
        int lo = (g == 0) ? 1 : int'(g);
        plan.delete();
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < hi; k++) plan.push_back(3'b110);
            if (i != int'(n) - 1)
                for (int k = 0; k < lo; k++) plan.push_back(3'b010);
        end
        plan.push_back(3'b001);
    endfunction

    // One clock of stimulus plus the model's expectation for the next cycle.
    task automatic step(input logic s, input logic a, input logic [WW-1:0] w,
                        input logic [WW-1:0] g, input logic [CW-1:0] n);
        logic [2:0] nxt;
        @(negedge clk);
        start = s; abort = a; width = w; gap = g; n_pulses = n;
        if (cur == 3'b000) begin
            if (s && !a) begin
                build_plan(w, g, n);
                nxt = plan.pop_front();
            end else begin
                nxt = 3'b000;
            end
        end else if (a) begin
            plan.delete();
            nxt = 3'b000;
        end else begin
            nxt = (plan.size() != 0) ? plan.pop_front() : 3'b000;
        end
        exp_q.push_back(nxt);
        cur = nxt;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, WW'($urandom), WW'($urandom), CW'($urandom));
    endtask

    // Run the current train out, throwing in random (ignored) start requests.
    task automatic run_until_idle(input int bound);
        int k = 0;
        while (cur != 3'b000 && k < bound) begin
            step($urandom_range(0, 2) == 0, 1'b0, WW'($urandom), WW'($urandom), CW'($urandom));
            k++;
        end
        if (cur != 3'b000) begin
            errors++;
            $display("FAIL run_until_idle: train still active after %0d cycles", bound);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("cycle", {pulse, busy, done}, mon_e);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {pulse, busy, done}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        // Basic train, then zero fields, then zero count.
        step(1'b1, 1'b0, 8'd3, 8'd2, 4'd2);
        run_until_idle(100);
        idle_step();
        step(1'b1, 1'b0, 8'd0, 8'd0, 4'd3);
        run_until_idle(100);
        idle_step();
        step(1'b1, 1'b0, WW'($urandom), WW'($urandom), 4'd0);
        run_until_idle(10);
        repeat (2) idle_step();

        // Abort in the middle of a pulse, then a normal train.
        step(1'b1, 1'b0, 8'd5, 8'd2, 4'd4);
        idle_step();
        idle_step();
        step(1'b0, 1'b1, 8'd1, 8'd1, 4'd1);
        repeat (3) idle_step();
        step(1'b1, 1'b0, 8'd2, 8'd1, 4'd2);
        run_until_idle(100);
        idle_step();

        // Start re-asserted mid-train and in the DONE cycle: both ignored.
        step(1'b1, 1'b0, 8'd3, 8'd2, 4'd2);
        idle_step();
        step(1'b1, 1'b0, 8'd1, 8'd1, 4'd5);
        for (int k = 0; k < 50 && cur != 3'b001; k++) idle_step();
        step(1'b1, 1'b0, 8'd1, 8'd1, 4'd5);
        repeat (3) idle_step();

        // Abort and start together in IDLE.
        step(1'b1, 1'b1, 8'd2, 8'd2, 4'd2);
        repeat (2) idle_step();

        // Maximum phase lengths.
        step(1'b1, 1'b0, 8'd255, 8'd255, 4'd2);
        run_until_idle(1000);
        idle_step();

        // Reset during HIGH drops the outputs without a clock edge.
        step(1'b1, 1'b0, 8'd6, 8'd1, 4'd3);
        repeat (2) idle_step();
        @(posedge clk);
        #2;
        check("pre_reset_high", {pulse, busy, done}, 3'b110);
        rst = 1'b1;
        #1;
        check("async_reset", {pulse, busy, done}, 3'b000);
        exp_q.delete();
        plan.delete();
        cur = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 8'd3, 8'd2, 4'd2);
        run_until_idle(100);
        idle_step();

        // Random traffic with sporadic starts and aborts.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 29) == 0,
                 WW'($urandom_range(0, 5)), WW'($urandom_range(0, 4)),
                 CW'($urandom_range(0, 5)));
        end

        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
